dot_product_mac_engine: RTL and testbench

Parametrised successor to the fixed-width dot-product unit. Holds two operand memories and one result memory, each 2**ADDRESS_WIDTH deep, and processes rows 0..last_addr using one multiply-accumulate per cycle. Supports a configurable element width and vector length, plus unsigned or signed element arithmetic. Sits between the host write/read interface and downstream consumers; the existing memory-fill and read-back flow is unchanged.

---
 rtl/dot_product_mac_engine.sv | 149 ++++++++++++++
 tb/tb_dot_product_mac_engine.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/dot_product_mac_engine.sv
// Dot-product engine: two operand memories and one result memory, one multiply-accumulate per cycle per row.
// Optional macro DOTP_ACCUMULATE_EN adds an accumulate input that adds new results onto stored ones.
module dot_product_mac_engine #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int VALUE_WIDTH   = 4,
  parameter int VECTOR_LENGTH = 3,
  localparam int DATA_WIDTH   = VALUE_WIDTH * VECTOR_LENGTH,
  localparam int RES_W        = 2 * DATA_WIDTH + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     WR,
  input  logic [ADDRESS_WIDTH-1:0] wraddr,
  input  logic [DATA_WIDTH-1:0]    dataIn1,
  input  logic [DATA_WIDTH-1:0]    dataIn2,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] last_addr,
  input  logic                     signed_mode,
`ifdef DOTP_ACCUMULATE_EN
  input  logic                     accumulate,
`endif
  output logic                     busy,
  output logic                     done,
  input  logic                     RD,
  input  logic [ADDRESS_WIDTH-1:0] rdaddr,
  output logic [RES_W-1:0]         final_output,
  output logic                     rd_valid
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam int EW    = $clog2(VECTOR_LENGTH + 1);
  localparam logic [EW-1:0] LAST_ELEM = EW'(VECTOR_LENGTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, MAC = 2'd2, STORE = 2'd3} state_t;

  state_t                   state_r, state_s;
  logic [DATA_WIDTH-1:0]    opa_mem [DEPTH];
  logic [DATA_WIDTH-1:0]    opb_mem [DEPTH];
  logic [RES_W-1:0]         res_mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] row_r, last_r;
  logic                     signed_r;
  logic [EW-1:0]            elem_r;
  logic [RES_W-1:0]         acc_r;
  logic [DATA_WIDTH-1:0]    a_r, b_r;
  logic [VALUE_WIDTH-1:0]   a_elem_s, b_elem_s;
  logic [RES_W-1:0]         a_ext_s, b_ext_s, prod_s;
`ifdef DOTP_ACCUMULATE_EN
  logic                     acc_en_r;
`endif

  // Next-state logic for the row sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (start) state_s = LOAD; else state_s = IDLE;
      LOAD:    state_s = MAC;
      MAC:     if (elem_r == LAST_ELEM) state_s = STORE; else state_s = MAC;
      STORE:   if (row_r == last_r) state_s = IDLE; else state_s = LOAD;
      default: state_s = IDLE;
    endcase
  end

  // Operand registers shift right one element per MAC cycle, so element k is always in the low bits.
  always_comb begin
    a_elem_s = a_r[VALUE_WIDTH-1:0];
    b_elem_s = b_r[VALUE_WIDTH-1:0];
    a_ext_s  = {{(RES_W-VALUE_WIDTH){signed_r & a_elem_s[VALUE_WIDTH-1]}}, a_elem_s};
    b_ext_s  = {{(RES_W-VALUE_WIDTH){signed_r & b_elem_s[VALUE_WIDTH-1]}}, b_elem_s};
    prod_s   = a_ext_s * b_ext_s;
  end

  // Sequencer state, counters, accumulator and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      row_r    <= '0;
      last_r   <= '0;
      signed_r <= 1'b0;
      elem_r   <= '0;
      acc_r    <= '0;
      a_r      <= '0;
      b_r      <= '0;
`ifdef DOTP_ACCUMULATE_EN
      acc_en_r <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      busy    <= (state_s != IDLE);
      done    <= (state_r == STORE) && (state_s == IDLE);
      case (state_r)
        IDLE: begin
          if (start) begin
            row_r    <= '0;
            last_r   <= last_addr;
            signed_r <= signed_mode;
            acc_r    <= '0;
`ifdef DOTP_ACCUMULATE_EN
            acc_en_r <= accumulate;
`endif
          end
        end
        LOAD: begin
          a_r    <= opa_mem[row_r];
          b_r    <= opb_mem[row_r];
          elem_r <= '0;
`ifdef DOTP_ACCUMULATE_EN
          acc_r  <= acc_en_r ? res_mem[row_r] : '0;
`else
          acc_r  <= '0;
`endif
        end
        MAC: begin
          acc_r  <= acc_r + prod_s;
          a_r    <= a_r >> VALUE_WIDTH;
          b_r    <= b_r >> VALUE_WIDTH;
          elem_r <= elem_r + EW'(1);
        end
        STORE: begin
          acc_r <= '0;
          if (row_r != last_r) row_r <= row_r + ADDRESS_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  // Memory arrays keep their contents through reset.
  always_ff @(posedge clk) begin
    if (state_r == IDLE && WR) begin
      opa_mem[wraddr] <= dataIn1;
      opb_mem[wraddr] <= dataIn2;
    end
    if (state_r == STORE) res_mem[row_r] <= acc_r;
  end

  // Registered result read port; reads the pre-store value on a same-cycle collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      final_output <= '0;
      rd_valid     <= 1'b0;
    end else begin
      rd_valid <= RD;
      if (RD) final_output <= res_mem[rdaddr];
    end
  end

endmodule

// File: tb/tb_dot_product_mac_engine.sv
// Scoreboard bench for dot_product_mac_engine: reads push expected results, a monitor pops on rd_valid.
module tb_dot_product_mac_engine;
  localparam int AW = 4, VW = 4, VL = 3, DW = 12, RW = 25;

  logic clk = 1'b0, rst = 1'b1, WR = 1'b0, start = 1'b0, signed_mode = 1'b0, RD = 1'b0;
  logic accumulate = 1'b0;
  logic [AW-1:0] wraddr = '0, last_addr = '0, rdaddr = '0;
  logic [DW-1:0] dataIn1 = '0, dataIn2 = '0;
  logic busy, done, rd_valid;
  logic [RW-1:0] final_output;

  logic [DW-1:0] ma [16];
  logic [DW-1:0] mb [16];
  logic [RW-1:0] mres [16];
  logic [RW-1:0] exp_q [$];
  int n_cmp = 0, n_fail = 0;

  dot_product_mac_engine #(.ADDRESS_WIDTH(AW), .VALUE_WIDTH(VW), .VECTOR_LENGTH(VL)) dut (
    .clk(clk), .rst(rst), .WR(WR), .wraddr(wraddr), .dataIn1(dataIn1), .dataIn2(dataIn2),
    .start(start), .last_addr(last_addr), .signed_mode(signed_mode),
`ifdef DOTP_ACCUMULATE_EN
    .accumulate(accumulate),
`endif
    .busy(busy), .done(done), .RD(RD), .rdaddr(rdaddr),
    .final_output(final_output), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference dot product with plain integer arithmetic, reduced modulo 2**RW.
  function automatic logic [RW-1:0] dot(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit sm);
    int sum = 0;
    for (int k = 0; k < VL; k++) begin
      int ea = int'((a >> (k*VW)) & 12'hF);
      int eb = int'((b >> (k*VW)) & 12'hF);
      if (sm && ea >= 8) ea -= 16;
      if (sm && eb >= 8) eb -= 16;
      sum += ea * eb;
    end
    return RW'(sum);
  endfunction

  task automatic write_row(input int addr, input logic [DW-1:0] a, input logic [DW-1:0] b);
    WR = 1'b1; wraddr = AW'(addr); dataIn1 = a; dataIn2 = b;
    @(posedge clk); #1;
    WR = 1'b0;
    ma[addr] = a; mb[addr] = b;
  endtask

  task automatic read_row(input int addr, input logic [RW-1:0] exp);
    RD = 1'b1; rdaddr = AW'(addr);
    exp_q.push_back(exp);
    @(posedge clk); #1;
    RD = 1'b0;
  endtask

  // Starts a run, optionally with a simultaneous row-0 write, optionally disturbing it mid-run.
  task automatic run(input int last, input bit sm, input bit acc, input bit disturb,
                     input bit wr_same, input logic [DW-1:0] wa, input logic [DW-1:0] wb);
    int n = 0;
    int expn = (last + 1) * (VL + 2);
    start = 1'b1; last_addr = AW'(last); signed_mode = sm; accumulate = acc;
    if (wr_same) begin
      WR = 1'b1; wraddr = '0; dataIn1 = wa; dataIn2 = wb;
      ma[0] = wa; mb[0] = wb;
    end
    @(posedge clk); #1;
    start = 1'b0; WR = 1'b0;
    check("busy_after_start", busy, 1);
    while (!done && n <= expn + 20) begin
      @(posedge clk); #1;
      n++;
      if (disturb && n == 7) begin
        start = 1'b1; last_addr = '0; WR = 1'b1; wraddr = 4'd10;
        dataIn1 = ~ma[10]; dataIn2 = DW'($urandom);
      end else if (disturb && n == 8) begin
        start = 1'b0; WR = 1'b0;
      end
    end
    check("done_latency", n, expn);
    check("busy_at_done", busy, 0);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    for (int r = 0; r <= last; r++)
      mres[r] = (acc ? mres[r] : '0) + dot(ma[r], mb[r], sm);
  endtask

  initial begin
    // Monitor: pops one expected value per rd_valid cycle.
    fork
      forever begin
        @(negedge clk);
        if (!rst && rd_valid) begin
          if (exp_q.size() == 0) check("unexpected_rd_valid", 1, 0);
          else check("read_data", final_output, exp_q.pop_front());
        end
      end
    join_none

    for (int r = 0; r < 16; r++) begin ma[r] = '0; mb[r] = '0; mres[r] = '0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_final_output", final_output, 0);

    // Fill every row, with a fixed row 0, then process all rows while poking start/WR mid-run.
    write_row(0, 12'h210, 12'h432);
    for (int r = 1; r < 16; r++) write_row(r, DW'($urandom), DW'($urandom));
    run(15, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    read_row(0, 25'd11);
    for (int r = 1; r < 16; r++) read_row(r, mres[r]);

    // last_addr = 0 touches row 0 only.
    write_row(0, DW'($urandom), DW'($urandom));
    write_row(1, DW'($urandom), DW'($urandom));
    run(0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    read_row(0, mres[0]);
    read_row(1, mres[1]);

    write_row(0, 12'hFFF, 12'h222);
    run(0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    read_row(0, 25'd90);
    run(0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    read_row(0, 25'h1FFFFFA);

    // Write and start in the same cycle: LOAD must see the new data.
    run(0, 1'b0, 1'b0, 1'b0, 1'b1, 12'hFFF, 12'hFFF);
    read_row(0, 25'd675);
    run(0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    read_row(0, 25'd3);

    // Reset during the MAC phase of row 2.
    for (int r = 0; r < 4; r++) write_row(r, DW'($urandom), DW'($urandom));
    start = 1'b1; last_addr = 4'd15; signed_mode = 1'b0; accumulate = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      check("no_done_before_abort", done, 0);
    end
    rst = 1'b1; #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    repeat (2) begin @(posedge clk); #1; check("abort_no_done", done, 0); end
    rst = 1'b0;
    for (int r = 0; r < 2; r++) mres[r] = dot(ma[r], mb[r], 1'b0);
    for (int r = 0; r < 4; r++) read_row(r, mres[r]);

`ifdef DOTP_ACCUMULATE_EN
    write_row(0, 12'h210, 12'h432);
    run(0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    read_row(0, 25'd11);
    run(0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    read_row(0, 25'd22);
`endif

    repeat (4) @(posedge clk);
    #1 check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
